// File: rtl/issue_queue_jmp_pkg.sv
// Shared widths and entry layout for the jump/branch-pipe issue queue.
package issue_queue_jmp_pkg;
   localparam int TAG_W = 6;
   localparam int POS_W = 6;
   localparam int F3_W  = 3;
   localparam int F7_W  = 7;
   localparam int REG_W = 5;
   localparam int PC_W  = 32;

   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic [TAG_W-1:0] prd;
      logic [TAG_W-1:0] prs1;
      logic [TAG_W-1:0] prs2;
      logic             prs1_valid;
      logic             prs2_valid;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [PC_W-1:0]  pc;
      logic             rdy1;
      logic             rdy2;
   } jmp_iq_entry_t;

   // A source is satisfied when unused, already ready, or hit this cycle.
   function automatic logic src_ok(logic used, logic rdy, logic hit);
      return !used || rdy || hit;
   endfunction
endpackage

// File: rtl/issue_queue_jmp_if.sv
// Dispatch, ALU wakeup and issue bundle between the rename/dispatch side and the jump-pipe queue.
interface issue_queue_jmp_if;
   import issue_queue_jmp_pkg::*;

   logic             disp_valid;
   logic             disp_ready;
   logic [POS_W-1:0] disp_pos;
   logic [TAG_W-1:0] disp_prd, disp_prs1, disp_prs2;
   logic             disp_prs1_valid, disp_prs2_valid;
   logic             disp_prs1_rdy, disp_prs2_rdy;
   logic [F3_W-1:0]  disp_funct3;
   logic [F7_W-1:0]  disp_funct7;
   logic [REG_W-1:0] disp_rs1, disp_rs2, disp_rd;
   logic [PC_W-1:0]  disp_pc;

   logic             alu_wake_valid;
   logic [TAG_W-1:0] alu_wake_prd;

   logic             req_issue;
   logic [POS_W-1:0] pos_issue;
   logic [TAG_W-1:0] prd_issue, prs1_issue, prs2_issue;
   logic             prs1_valid_issue, prs2_valid_issue;
   logic [F3_W-1:0]  funct3_issue;
   logic [F7_W-1:0]  funct7_issue;
   logic [REG_W-1:0] rs1_issue, rs2_issue, rd_issue;
   logic [PC_W-1:0]  pc_issue;
   logic             alubypass1_issue, alubypass2_issue;
   logic             jmpbypass1_issue, jmpbypass2_issue;

   modport master (
      output disp_valid, disp_pos, disp_prd, disp_prs1, disp_prs2,
             disp_prs1_valid, disp_prs2_valid, disp_prs1_rdy, disp_prs2_rdy,
             disp_funct3, disp_funct7, disp_rs1, disp_rs2, disp_rd, disp_pc,
             alu_wake_valid, alu_wake_prd,
      input  disp_ready, req_issue, pos_issue, prd_issue, prs1_issue, prs2_issue,
             prs1_valid_issue, prs2_valid_issue, funct3_issue, funct7_issue,
             rs1_issue, rs2_issue, rd_issue, pc_issue,
             alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue
   );

   modport slave (
      input  disp_valid, disp_pos, disp_prd, disp_prs1, disp_prs2,
             disp_prs1_valid, disp_prs2_valid, disp_prs1_rdy, disp_prs2_rdy,
             disp_funct3, disp_funct7, disp_rs1, disp_rs2, disp_rd, disp_pc,
             alu_wake_valid, alu_wake_prd,
      output disp_ready, req_issue, pos_issue, prd_issue, prs1_issue, prs2_issue,
             prs1_valid_issue, prs2_valid_issue, funct3_issue, funct7_issue,
             rs1_issue, rs2_issue, rd_issue, pc_issue,
             alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue
   );
endinterface

// File: rtl/issue_queue_jmp_tag_match.sv
// Compares two source tags against the ALU and jump-pipe wakeup broadcasts.
module tag_match
   import issue_queue_jmp_pkg::*;
(
   input  logic [TAG_W-1:0] prs1,
   input  logic [TAG_W-1:0] prs2,
   input  logic             alu_valid,
   input  logic [TAG_W-1:0] alu_prd,
   input  logic             jmp_valid,
   input  logic [TAG_W-1:0] jmp_prd,
   output logic [1:0]       alu_hit,
   output logic [1:0]       jmp_hit
);
   assign alu_hit = {alu_valid && (alu_prd == prs2), alu_valid && (alu_prd == prs1)};
   assign jmp_hit = {jmp_valid && (jmp_prd == prs2), jmp_valid && (jmp_prd == prs1)};
endmodule

// File: rtl/issue_queue_jmp.sv
// In-order jump/branch issue queue: oldest entry issues once its sources are ready or woken this cycle.
module issue_queue_jmp
   import issue_queue_jmp_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               reset,
   input logic               flush_iq,
   issue_queue_jmp_if.slave  bus
);
   jmp_iq_entry_t    q [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;

   logic [DEPTH-1:0] live;
   logic [1:0]       alu_hit [DEPTH];
   logic [1:0]       jmp_hit [DEPTH];
   logic [1:0]       d_alu, d_jmp;
   jmp_iq_entry_t    hd, new_ent;
   logic             go, push;
   logic             jmp_wv;
   logic [TAG_W-1:0] jmp_wp;

   assign hd = q[head];

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [PTR_W-1:0] rel;
      assign rel     = PTR_W'(g) - head;
      assign live[g] = {1'b0, rel} < count;

      tag_match u_tm (
         .prs1      (q[g].prs1),
         .prs2      (q[g].prs2),
         .alu_valid (bus.alu_wake_valid),
         .alu_prd   (bus.alu_wake_prd),
         .jmp_valid (jmp_wv),
         .jmp_prd   (jmp_wp),
         .alu_hit   (alu_hit[g]),
         .jmp_hit   (jmp_hit[g])
      );
   end

   tag_match u_disp_tm (
      .prs1      (bus.disp_prs1),
      .prs2      (bus.disp_prs2),
      .alu_valid (bus.alu_wake_valid),
      .alu_prd   (bus.alu_wake_prd),
      .jmp_valid (jmp_wv),
      .jmp_prd   (jmp_wp),
      .alu_hit   (d_alu),
      .jmp_hit   (d_jmp)
   );

   // The jump-pipe broadcast comes from the head itself, so only the ALU
   // broadcast can complete the head's operands; this also keeps go loop-free.
   assign go     = (count != '0)
                   && src_ok(hd.prs1_valid, hd.rdy1, alu_hit[head][0])
                   && src_ok(hd.prs2_valid, hd.rdy2, alu_hit[head][1]);
   assign jmp_wv = go && (hd.rd != '0);
   assign jmp_wp = hd.prd;

   assign bus.disp_ready = (count != (PTR_W+1)'(DEPTH));
   assign push           = bus.disp_valid && bus.disp_ready;

   always_comb begin
      new_ent            = '0;
      new_ent.pos        = bus.disp_pos;
      new_ent.prd        = bus.disp_prd;
      new_ent.prs1       = bus.disp_prs1;
      new_ent.prs2       = bus.disp_prs2;
      new_ent.prs1_valid = bus.disp_prs1_valid;
      new_ent.prs2_valid = bus.disp_prs2_valid;
      new_ent.funct3     = bus.disp_funct3;
      new_ent.funct7     = bus.disp_funct7;
      new_ent.rs1        = bus.disp_rs1;
      new_ent.rs2        = bus.disp_rs2;
      new_ent.rd         = bus.disp_rd;
      new_ent.pc         = bus.disp_pc;
      new_ent.rdy1       = src_ok(bus.disp_prs1_valid, bus.disp_prs1_rdy, d_alu[0] || d_jmp[0]);
      new_ent.rdy2       = src_ok(bus.disp_prs2_valid, bus.disp_prs2_rdy, d_alu[1] || d_jmp[1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (flush_iq) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && q[i].prs1_valid && (alu_hit[i][0] || jmp_hit[i][0])) q[i].rdy1 <= 1'b1;
            if (live[i] && q[i].prs2_valid && (alu_hit[i][1] || jmp_hit[i][1])) q[i].rdy2 <= 1'b1;
         end
         if (push) begin
            q[tail] <= new_ent;
            tail    <= tail + 1'b1;
         end
         if (go) head <= head + 1'b1;
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, go};
      end
   end

   assign bus.req_issue        = go;
   assign bus.pos_issue        = hd.pos;
   assign bus.prd_issue        = hd.prd;
   assign bus.prs1_issue       = hd.prs1;
   assign bus.prs2_issue       = hd.prs2;
   assign bus.prs1_valid_issue = hd.prs1_valid;
   assign bus.prs2_valid_issue = hd.prs2_valid;
   assign bus.funct3_issue     = hd.funct3;
   assign bus.funct7_issue     = hd.funct7;
   assign bus.rs1_issue        = hd.rs1;
   assign bus.rs2_issue        = hd.rs2;
   assign bus.rd_issue         = hd.rd;
   assign bus.pc_issue         = hd.pc;

   assign bus.alubypass1_issue = hd.prs1_valid && !hd.rdy1 && alu_hit[head][0];
   assign bus.alubypass2_issue = hd.prs2_valid && !hd.rdy2 && alu_hit[head][1];
   assign bus.jmpbypass1_issue = hd.prs1_valid && !hd.rdy1 && !alu_hit[head][0] && jmp_hit[head][0];
   assign bus.jmpbypass2_issue = hd.prs2_valid && !hd.rdy2 && !alu_hit[head][1] && jmp_hit[head][1];
endmodule

// File: tb/tb_issue_queue_jmp.sv
// Jump-pipe issue queue bench: directed scenarios plus random traffic against a FIFO reference model.
module tb_issue_queue_jmp;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset, flush_iq;
   always #5 clk = ~clk;

   issue_queue_jmp_if bus();

   issue_queue_jmp #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush_iq (flush_iq),
      .bus      (bus)
   );

   typedef struct {
      logic [5:0]  pos, prd, s1, s2;
      logic        u1, u2, r1, r2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc;
   } uop_t;

   uop_t mq[$];
   int   checks = 0;
   int   errors = 0;
   logic seen_req, seen_dr;
   logic [3:0] seen_byp;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // One cycle: compare outputs against the model mid-cycle, then advance the model at the edge.
   task automatic tick();
      uop_t h, e;
      bit   elig, a1, a2, jw, ready_before, h1, h2;
      logic [5:0] jp;
      h = '{default:'0};
      elig = 0; a1 = 0; a2 = 0;
      @(negedge clk);
      ready_before = (mq.size() != DEPTH);
      chk("disp_ready", bus.disp_ready, ready_before);
      if (mq.size() > 0) begin
         h  = mq[0];
         a1 = bus.alu_wake_valid && (bus.alu_wake_prd == h.s1);
         a2 = bus.alu_wake_valid && (bus.alu_wake_prd == h.s2);
         elig = (!h.u1 || h.r1 || a1) && (!h.u2 || h.r2 || a2);
      end
      jw = elig && (h.rd != 0);
      jp = h.prd;
      seen_req = bus.req_issue;
      seen_dr  = bus.disp_ready;
      seen_byp = {bus.alubypass1_issue, bus.alubypass2_issue, bus.jmpbypass1_issue, bus.jmpbypass2_issue};
      chk("req_issue", bus.req_issue, elig);
      if (elig) begin
         chk("fields", {bus.pos_issue, bus.prd_issue, bus.prs1_issue, bus.prs2_issue,
                        bus.prs1_valid_issue, bus.prs2_valid_issue, bus.funct3_issue,
                        bus.funct7_issue, bus.rs1_issue, bus.rs2_issue, bus.rd_issue, bus.pc_issue},
                       {h.pos, h.prd, h.s1, h.s2, h.u1, h.u2, h.f3, h.f7, h.rs1, h.rs2, h.rd, h.pc});
         chk("bypass", seen_byp,
             {h.u1 && !h.r1 && a1, h.u2 && !h.r2 && a2,
              h.u1 && !h.r1 && !a1 && jw && (jp == h.s1),
              h.u2 && !h.r2 && !a2 && jw && (jp == h.s2)});
      end
      @(posedge clk);
      if (reset || flush_iq) mq.delete();
      else begin
         for (int i = 0; i < mq.size(); i++) begin
            e  = mq[i];
            h1 = (bus.alu_wake_valid && bus.alu_wake_prd == e.s1) || (jw && jp == e.s1);
            h2 = (bus.alu_wake_valid && bus.alu_wake_prd == e.s2) || (jw && jp == e.s2);
            if (e.u1 && h1) e.r1 = 1;
            if (e.u2 && h2) e.r2 = 1;
            mq[i] = e;
         end
         if (elig) void'(mq.pop_front());
         if (bus.disp_valid && ready_before) begin
            e.pos = bus.disp_pos;  e.prd = bus.disp_prd;
            e.s1 = bus.disp_prs1;  e.s2 = bus.disp_prs2;
            e.u1 = bus.disp_prs1_valid; e.u2 = bus.disp_prs2_valid;
            e.f3 = bus.disp_funct3; e.f7 = bus.disp_funct7;
            e.rs1 = bus.disp_rs1; e.rs2 = bus.disp_rs2; e.rd = bus.disp_rd; e.pc = bus.disp_pc;
            h1 = (bus.alu_wake_valid && bus.alu_wake_prd == e.s1) || (jw && jp == e.s1);
            h2 = (bus.alu_wake_valid && bus.alu_wake_prd == e.s2) || (jw && jp == e.s2);
            e.r1 = !e.u1 || bus.disp_prs1_rdy || h1;
            e.r2 = !e.u2 || bus.disp_prs2_rdy || h2;
            mq.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle();
      bus.disp_valid = 0; bus.alu_wake_valid = 0; flush_iq = 0; reset = 0;
   endtask

   task automatic disp(logic [5:0] pos, logic [5:0] prd, logic [5:0] s1, logic u1, logic r1,
                       logic [5:0] s2, logic u2, logic r2, logic [4:0] rd, logic [31:0] pc);
      bus.disp_valid = 1; bus.disp_pos = pos; bus.disp_prd = prd;
      bus.disp_prs1 = s1; bus.disp_prs1_valid = u1; bus.disp_prs1_rdy = r1;
      bus.disp_prs2 = s2; bus.disp_prs2_valid = u2; bus.disp_prs2_rdy = r2;
      bus.disp_rd = rd; bus.disp_pc = pc;
      bus.disp_funct3 = 3'($urandom); bus.disp_funct7 = 7'($urandom);
      bus.disp_rs1 = 5'($urandom); bus.disp_rs2 = 5'($urandom);
   endtask

   task automatic wake(logic [5:0] t);
      bus.alu_wake_valid = 1; bus.alu_wake_prd = t;
   endtask

   initial begin
      idle();
      disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.disp_valid = 0; bus.alu_wake_prd = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      idle();
      tick();
      chk("rst_bypass", seen_byp, 4'b0000);
      chk("rst_ready", seen_dr, 1'b1);

      // jal with no sources: issuable one cycle after dispatch
      disp(6'd3, 6'd20, 0, 0, 0, 0, 0, 0, 5'd1, 32'h1000); tick();
      chk("jal_not_same_cycle", seen_req, 1'b0);
      idle(); tick();
      chk("jal_issue", seen_req, 1'b1);
      tick();
      chk("jal_drained", seen_req, 1'b0);

      // branch waiting on prs2=9, released by a same-cycle ALU wake
      disp(6'd4, 6'd21, 6'd5, 1, 1, 6'd9, 1, 0, 5'd0, 32'h2000); tick();
      idle(); tick(); tick();
      wake(6'd9); tick();
      chk("alu_bypass_issue", {seen_req, seen_byp}, 5'b1_0100);
      idle(); tick();

      // jalr blocked on 30 writes prd 12; jr behind it reads prd 12
      disp(6'd5, 6'd12, 6'd30, 1, 0, 0, 0, 0, 5'd1, 32'h3000); tick();
      disp(6'd6, 6'd22, 6'd12, 1, 0, 0, 0, 0, 5'd0, 32'h3004); tick();
      idle(); wake(6'd30); tick();
      chk("jalr_issue", {seen_req, seen_byp}, 5'b1_1000);
      idle(); tick();
      chk("jr_issue_next", {seen_req, seen_byp}, 5'b1_0000);

      // fill all slots behind tag 40, then unblock while a dispatch is offered
      for (int i = 0; i < DEPTH; i++) begin
         disp(6'(8 + i), 6'(48 + i), 6'd40, 1, 0, 0, 0, 0, 5'd0, 32'h4000 + 4 * i); tick();
      end
      idle(); tick();
      chk("full_ready", seen_dr, 1'b0);
      disp(6'd33, 6'd34, 0, 0, 0, 0, 0, 0, 5'd2, 32'h5000); wake(6'd40); tick();
      chk("full_refused", {seen_req, seen_dr}, 2'b10);
      bus.alu_wake_valid = 0; tick();
      chk("wrap_accept", seen_dr, 1'b1);
      idle(); repeat (DEPTH + 2) tick();

      // flush with 4 blocked entries and a same-cycle dispatch
      for (int i = 0; i < 4; i++) begin
         disp(6'(16 + i), 6'(56 + i), 6'd41, 1, 0, 0, 0, 0, 5'd0, 32'h6000 + 4 * i); tick();
      end
      disp(6'd35, 6'd36, 0, 0, 0, 0, 0, 0, 5'd0, 32'h7000); flush_iq = 1; tick();
      idle(); tick();
      chk("flush_empty", {seen_req, seen_dr}, 2'b01);
      tick();
      chk("flush_discarded", seen_req, 1'b0);

      // wake for 7 at the dispatch edge of an entry waiting on 7
      disp(6'd37, 6'd38, 6'd7, 1, 0, 0, 0, 0, 5'd0, 32'h8000); wake(6'd7); tick();
      idle(); tick();
      chk("dispatch_wake", {seen_req, seen_byp}, 5'b1_0000);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         idle();
         if ($urandom_range(0, 99) < 60)
            disp(6'($urandom), 6'($urandom_range(1, 15)), 6'($urandom_range(0, 15)),
                 1'($urandom), $urandom_range(0, 3) == 0, 6'($urandom_range(0, 15)),
                 1'($urandom), $urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 1) == 1) wake(6'($urandom_range(0, 15)));
         flush_iq = ($urandom_range(0, 59) == 0);
         reset    = ($urandom_range(0, 249) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
